gps_ack_peak_sel: RTL and testbench

//  Parametrised peak selector behind the multi-channel GPS acquisition correlator.

---
 rtl/gps_ack_pkg.sv | 16 +
 rtl/gps_ack_peak_sel_if.sv | 52 +++++
 rtl/gps_ack_mag.sv | 22 ++
 rtl/gps_ack_peak_sel.sv | 175 +++++++++++++++++
 tb/tb_gps_ack_peak_sel.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gps_ack_pkg.sv
// Shared types and helpers for the GPS acquisition peak selector.
package gps_ack_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        CMP   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // |I|+|Q| of two signed INT_W values needs one extra bit so the sum never wraps
    function automatic int mag_w(input int int_w);
        return int_w + 1;
    endfunction

endpackage

// File: rtl/gps_ack_peak_sel_if.sv
// Cell input bus and result stream of the peak selector, with driver/DUT views.
interface gps_ack_peak_sel_if
    import gps_ack_pkg::*;
#(
    parameter int NUM_CH  = 8,
    parameter int INT_W   = 14,
    parameter int SAT_W   = 6,
    parameter int PHASE_W = 10,
    parameter int FRAC_W  = 5,
    parameter int DOP_W   = 16
);
    localparam int MAG_W = mag_w(INT_W);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                      search_start;
    logic                      corr_complete;
    logic                      search_complete;
    logic [NUM_CH*SAT_W-1:0]   sat;
    logic [NUM_CH*INT_W-1:0]   integ_i;
    logic [NUM_CH*INT_W-1:0]   integ_q;
    logic [PHASE_W-1:0]        code_phase;
    logic [FRAC_W-1:0]         code_nco_frac;
    logic [DOP_W-1:0]          doppler_omega;
    logic [MAG_W-1:0]          threshold;
    logic                      busy;
    logic                      overrun;
    logic                      res_valid;
    logic                      res_ready;
    logic [CH_W-1:0]           res_ch;
    logic [SAT_W-1:0]          res_sat;
    logic [MAG_W-1:0]          res_mag;
    logic [PHASE_W-1:0]        res_phase;
    logic [FRAC_W-1:0]         res_frac;
    logic [DOP_W-1:0]          res_dop;
    logic                      res_detect;
    logic                      done;

    modport slave (
        input  search_start, corr_complete, search_complete, sat, integ_i, integ_q,
               code_phase, code_nco_frac, doppler_omega, threshold, res_ready,
        output busy, overrun, res_valid, res_ch, res_sat, res_mag, res_phase,
               res_frac, res_dop, res_detect, done
    );

    modport master (
        output search_start, corr_complete, search_complete, sat, integ_i, integ_q,
               code_phase, code_nco_frac, doppler_omega, threshold, res_ready,
        input  busy, overrun, res_valid, res_ch, res_sat, res_mag, res_phase,
               res_frac, res_dop, res_detect, done
    );

endinterface

// File: rtl/gps_ack_mag.sv
// Combinational |I|+|Q|; the most negative integrator value maps to its exact magnitude.
module gps_ack_mag #(
    parameter  int INT_W = 14,
    localparam int MAG_W = INT_W + 1
) (
    input  logic [INT_W-1:0] i_i,
    input  logic [INT_W-1:0] i_q,
    output logic [MAG_W-1:0] o_mag
);
    logic [MAG_W-1:0] w_i_ext;
    logic [MAG_W-1:0] w_q_ext;
    logic [MAG_W-1:0] w_abs_i;
    logic [MAG_W-1:0] w_abs_q;

    // Sign-extend by one bit first so negating -2^(INT_W-1) cannot overflow
    assign w_i_ext = {i_i[INT_W-1], i_i};
    assign w_q_ext = {i_q[INT_W-1], i_q};
    assign w_abs_i = i_i[INT_W-1] ? (~w_i_ext + MAG_W'(1)) : w_i_ext;
    assign w_abs_q = i_q[INT_W-1] ? (~w_q_ext + MAG_W'(1)) : w_q_ext;
    assign o_mag   = w_abs_i + w_abs_q;

endmodule

// File: rtl/gps_ack_peak_sel.sv
// Per-channel peak tracker over a code-phase x Doppler search; drains one record per channel.
module gps_ack_peak_sel
    import gps_ack_pkg::*;
#(
    parameter int NUM_CH  = 8,
    parameter int INT_W   = 14,
    parameter int SAT_W   = 6,
    parameter int PHASE_W = 10,
    parameter int FRAC_W  = 5,
    parameter int DOP_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    gps_ack_peak_sel_if.slave  bus
);
    localparam int MAG_W = mag_w(INT_W);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef struct packed {
        logic [SAT_W-1:0]   sat;
        logic [MAG_W-1:0]   mag;
        logic [PHASE_W-1:0] phase;
        logic [FRAC_W-1:0]  frac;
        logic [DOP_W-1:0]   dop;
    } peak_rec_t;

    state_t                  r_state;
    state_t                  w_next;
    logic                    w_done_set;
    logic [CH_W-1:0]         r_ch;
    peak_rec_t               r_tab [NUM_CH];
    logic [NUM_CH*SAT_W-1:0] r_snap_sat;
    logic [NUM_CH*INT_W-1:0] r_snap_i;
    logic [NUM_CH*INT_W-1:0] r_snap_q;
    logic [PHASE_W-1:0]      r_snap_phase;
    logic [FRAC_W-1:0]       r_snap_frac;
    logic [DOP_W-1:0]        r_snap_dop;
    logic [MAG_W-1:0]        r_thr;
    logic                    r_overrun;
    logic                    r_pending;
    logic                    r_done;

    logic                    w_last;
    logic                    w_snap;
    logic                    w_accept;
    logic                    w_valid;
    logic                    w_upd;
    logic [SAT_W-1:0]        w_cur_sat;
    logic [INT_W-1:0]        w_cur_i;
    logic [INT_W-1:0]        w_cur_q;
    logic [MAG_W-1:0]        w_mag;
    peak_rec_t               w_new_rec;
    peak_rec_t               w_out;

    assign w_last    = (r_ch == CH_W'(NUM_CH - 1));
    assign w_snap    = (r_state == ARMED) && bus.corr_complete && !bus.search_start;
    assign w_valid   = (r_state == DRAIN);
    assign w_accept  = w_valid && bus.res_ready;
    assign w_cur_sat = r_snap_sat[int'(r_ch)*SAT_W +: SAT_W];
    assign w_cur_i   = r_snap_i[int'(r_ch)*INT_W +: INT_W];
    assign w_cur_q   = r_snap_q[int'(r_ch)*INT_W +: INT_W];

    gps_ack_mag #(.INT_W(INT_W)) u_mag (
        .i_i   (w_cur_i),
        .i_q   (w_cur_q),
        .o_mag (w_mag)
    );

    // A new PRN in the slot replaces the entry; same PRN needs a strictly larger peak
    assign w_upd = (r_state == CMP) && !bus.search_start &&
                   ((w_cur_sat != r_tab[r_ch].sat) || (w_mag > r_tab[r_ch].mag));
    assign w_new_rec = '{sat: w_cur_sat, mag: w_mag, phase: r_snap_phase,
                         frac: r_snap_frac, dop: r_snap_dop};

    always_comb begin
        w_next     = r_state;
        w_done_set = 1'b0;
        if (bus.search_start) begin
            w_next = ARMED;
        end else begin
            case (r_state)
                IDLE:  w_next = IDLE;
                ARMED: begin
                    if (bus.corr_complete)
                        w_next = CMP;
                    else if (bus.search_complete)
                        w_next = DRAIN;
                end
                CMP: begin
                    if (w_last)
                        w_next = (r_pending || bus.search_complete) ? DRAIN : ARMED;
                end
                DRAIN: begin
                    if (w_accept && w_last) begin
                        w_next     = IDLE;
                        w_done_set = 1'b1;
                    end
                end
            endcase
        end
    end

    // The channel counter restarts on every state change so CMP and DRAIN both begin at ch0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_ch      <= '0;
            r_pending <= 1'b0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
            r_thr     <= '0;
        end else begin
            r_state   <= w_next;
            r_pending <= (w_next == CMP) && (r_pending || bus.search_complete);
            r_done    <= w_done_set;
            if (w_next != r_state)
                r_ch <= '0;
            else if ((r_state == CMP) || w_accept)
                r_ch <= r_ch + CH_W'(1);
            if (bus.search_start) begin
                r_overrun <= 1'b0;
                r_thr     <= bus.threshold;
            end else if ((r_state == CMP) && bus.corr_complete) begin
                r_overrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snap_sat   <= '0;
            r_snap_i     <= '0;
            r_snap_q     <= '0;
            r_snap_phase <= '0;
            r_snap_frac  <= '0;
            r_snap_dop   <= '0;
        end else if (w_snap) begin
            r_snap_sat   <= bus.sat;
            r_snap_i     <= bus.integ_i;
            r_snap_q     <= bus.integ_q;
            r_snap_phase <= bus.code_phase;
            r_snap_frac  <= bus.code_nco_frac;
            r_snap_dop   <= bus.doppler_omega;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH; k++)
                r_tab[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (bus.search_start)
                    r_tab[k] <= '0;
                else if (w_upd && (r_ch == CH_W'(k)))
                    r_tab[k] <= w_new_rec;
            end
        end
    end

    // Record fields are forced to zero whenever no record is being offered
    assign w_out          = r_tab[r_ch];
    assign bus.busy       = (r_state == CMP) || (r_state == DRAIN);
    assign bus.overrun    = r_overrun;
    assign bus.done       = r_done;
    assign bus.res_valid  = w_valid;
    assign bus.res_ch     = w_valid ? r_ch : '0;
    assign bus.res_sat    = w_valid ? w_out.sat : '0;
    assign bus.res_mag    = w_valid ? w_out.mag : '0;
    assign bus.res_phase  = w_valid ? w_out.phase : '0;
    assign bus.res_frac   = w_valid ? w_out.frac : '0;
    assign bus.res_dop    = w_valid ? w_out.dop : '0;
    assign bus.res_detect = w_valid && (w_out.mag >= r_thr);

endmodule

// File: tb/tb_gps_ack_peak_sel.sv
// Directed bench for gps_ack_peak_sel: peak model per channel plus a per-cycle record monitor.
module tb_gps_ack_peak_sel;
    localparam int NCH = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    gps_ack_peak_sel_if #(.NUM_CH(NCH)) bus ();

    gps_ack_peak_sel #(.NUM_CH(NCH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int compareCount = 0;
    int failCount    = 0;

    // Per-cell stimulus and the expected peak table
    int cellSat [NCH];
    int cellI   [NCH];
    int cellQ   [NCH];
    int expSat  [NCH];
    int expMag  [NCH];
    int expPhase[NCH];
    int expFrac [NCH];
    int expDop  [NCH];
    int expThr = 0;

    // Records captured by the monitor
    int gotSat   [NCH];
    int gotMag   [NCH];
    int gotPhase [NCH];
    int gotDetect[NCH];
    int recCount = 0;
    int doneCount = 0;
    bit monClear = 1'b0;

    int expCh = 0;
    bit lastAcceptPrev = 1'b0;
    bit prevHold = 1'b0;
    int holdMag = 0;
    int holdPhase = 0;
    int holdCh = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        compareCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int absInt(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic startSearch(input int thr);
        bus.search_start = 1'b1;
        bus.threshold    = 15'(thr);
        monClear         = 1'b1;
        tick();
        bus.search_start = 1'b0;
        monClear         = 1'b0;
        expThr = thr;
        for (int k = 0; k < NCH; k++) begin
            expSat[k] = 0; expMag[k] = 0; expPhase[k] = 0; expFrac[k] = 0; expDop[k] = 0;
        end
    endtask

    // Presents one correlation cell; the model absorbs it only when acceptance is expected
    task automatic applyStimulus(input int phase, input int frac, input int dop,
                                 input bit expectAccept, input bit withComplete);
        for (int k = 0; k < NCH; k++) begin
            bus.sat[k*6 +: 6]      = 6'(cellSat[k]);
            bus.integ_i[k*14 +: 14] = 14'(cellI[k]);
            bus.integ_q[k*14 +: 14] = 14'(cellQ[k]);
        end
        bus.code_phase      = 10'(phase);
        bus.code_nco_frac   = 5'(frac);
        bus.doppler_omega   = 16'(dop);
        bus.corr_complete   = 1'b1;
        bus.search_complete = withComplete;
        tick();
        bus.corr_complete   = 1'b0;
        bus.search_complete = 1'b0;
        if (expectAccept) begin
            for (int k = 0; k < NCH; k++) begin
                int m;
                m = absInt(cellI[k]) + absInt(cellQ[k]);
                if (cellSat[k] != expSat[k] || m > expMag[k]) begin
                    expSat[k] = cellSat[k]; expMag[k] = m; expPhase[k] = phase;
                    expFrac[k] = frac; expDop[k] = dop;
                end
            end
        end
    endtask

    task automatic searchComplete();
        bus.search_complete = 1'b1;
        tick();
        bus.search_complete = 1'b0;
    endtask

    task automatic drainAll(input bit stall);
        bit sawDone;
        sawDone = 1'b0;
        doneCount = 0;
        for (int c = 0; c < 300 && !sawDone; c++) begin
            bus.res_ready = stall ? ((c >= 5) && (c % 2 == 1)) : 1'b1;
            tick();
            if (bus.done) begin
                sawDone = 1'b1;
                doneCount++;
            end
        end
        bus.res_ready = 1'b0;
        repeat (3) begin
            tick();
            if (bus.done) doneCount++;
        end
        checkOutput("drain_done_once", doneCount, 1);
    endtask

    // Record monitor: checks every offered record against the model and the done pulse timing
    always @(negedge clk) begin
        if (!rst_n || monClear) begin
            expCh = 0; lastAcceptPrev = 1'b0; prevHold = 1'b0;
            if (monClear) recCount = 0;
        end else begin
            checkOutput("done_timing", int'(bus.done), int'(lastAcceptPrev));
            lastAcceptPrev = 1'b0;
            if (bus.res_valid) begin
                if (prevHold) begin
                    checkOutput("stall_ch", int'(bus.res_ch), holdCh);
                    checkOutput("stall_mag", int'(bus.res_mag), holdMag);
                    checkOutput("stall_phase", int'(bus.res_phase), holdPhase);
                end
                checkOutput("rec_busy", int'(bus.busy), 1);
                checkOutput("rec_ch", int'(bus.res_ch), expCh);
                checkOutput("rec_sat", int'(bus.res_sat), expSat[expCh]);
                checkOutput("rec_mag", int'(bus.res_mag), expMag[expCh]);
                checkOutput("rec_phase", int'(bus.res_phase), expPhase[expCh]);
                checkOutput("rec_frac", int'(bus.res_frac), expFrac[expCh]);
                checkOutput("rec_dop", int'($signed(bus.res_dop)), expDop[expCh]);
                checkOutput("rec_detect", int'(bus.res_detect), int'(expMag[expCh] >= expThr));
                if (bus.res_ready) begin
                    gotSat[expCh]    = int'(bus.res_sat);
                    gotMag[expCh]    = int'(bus.res_mag);
                    gotPhase[expCh]  = int'(bus.res_phase);
                    gotDetect[expCh] = int'(bus.res_detect);
                    recCount++;
                    prevHold = 1'b0;
                    if (expCh == NCH - 1) begin
                        lastAcceptPrev = 1'b1;
                        expCh = 0;
                    end else begin
                        expCh++;
                    end
                end else begin
                    prevHold  = 1'b1;
                    holdCh    = int'(bus.res_ch);
                    holdMag   = int'(bus.res_mag);
                    holdPhase = int'(bus.res_phase);
                end
            end else begin
                prevHold = 1'b0;
            end
        end
    end

    task automatic runPeakSearch(input int thr);
        startSearch(thr);
        for (int k = 0; k < NCH; k++) cellSat[k] = k + 1;
        for (int k = 0; k < NCH; k++) begin cellI[k] = 10*k;  cellQ[k] = -5*k; end
        cellI[0] = 100;  cellQ[0] = -50;
        applyStimulus(5, 3, 100, 1'b1, 1'b0);
        repeat (NCH) tick();
        for (int k = 0; k < NCH; k++) begin cellI[k] = -20*k; cellQ[k] = 3; end
        cellI[0] = -300; cellQ[0] = 20;
        applyStimulus(9, 7, -250, 1'b1, 1'b0);
        repeat (NCH) tick();
        for (int k = 0; k < NCH; k++) begin cellI[k] = 7*k;   cellQ[k] = 7*k; end
        cellI[0] = 200;  cellQ[0] = 100;
        applyStimulus(12, 1, 400, 1'b1, 1'b0);
        repeat (NCH) tick();
        searchComplete();
        drainAll(1'b0);
    endtask

    initial begin
        bus.search_start = 1'b0; bus.corr_complete = 1'b0; bus.search_complete = 1'b0;
        bus.sat = '0; bus.integ_i = '0; bus.integ_q = '0; bus.code_phase = '0;
        bus.code_nco_frac = '0; bus.doppler_omega = '0; bus.threshold = '0; bus.res_ready = 1'b0;
        for (int k = 0; k < NCH; k++) begin cellSat[k] = 0; cellI[k] = 0; cellQ[k] = 0; end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        checkOutput("reset_busy", int'(bus.busy), 0);
        checkOutput("reset_overrun", int'(bus.overrun), 0);
        checkOutput("reset_valid", int'(bus.res_valid), 0);
        checkOutput("reset_done", int'(bus.done), 0);
        checkOutput("reset_mag", int'(bus.res_mag), 0);

        $display("[TB] peak tracking, threshold 300 then 321");
        runPeakSearch(300);
        checkOutput("t2_ch0_mag", gotMag[0], 320);
        checkOutput("t2_ch0_phase", gotPhase[0], 9);
        checkOutput("t2_detect_300", gotDetect[0], 1);
        runPeakSearch(321);
        checkOutput("t2_detect_321", gotDetect[0], 0);

        $display("[TB] full-scale negative integrators, combined complete");
        startSearch(0);
        for (int k = 0; k < NCH; k++) begin cellSat[k] = 0; cellI[k] = 0; cellQ[k] = 0; end
        cellSat[3] = 3; cellI[3] = -8192; cellQ[3] = -8192;
        applyStimulus(33, 2, -1, 1'b1, 1'b1);
        checkOutput("t3_busy_cmp", int'(bus.busy), 1);
        drainAll(1'b0);
        checkOutput("t3_ch3_mag", gotMag[3], 16384);
        checkOutput("t3_unused_mag", gotMag[5], 0);
        checkOutput("t3_unused_detect", gotDetect[5], 1);

        $display("[TB] corr_complete during compare");
        startSearch(50);
        for (int k = 0; k < NCH; k++) begin cellSat[k] = k + 1; cellI[k] = 40 + k; cellQ[k] = -k; end
        applyStimulus(100, 4, 7, 1'b1, 1'b0);
        repeat (2) tick();
        for (int k = 0; k < NCH; k++) begin cellI[k] = 1000; cellQ[k] = 1000; end
        applyStimulus(200, 9, 8, 1'b0, 1'b0);
        checkOutput("t4_overrun", int'(bus.overrun), 1);
        repeat (5) tick();
        searchComplete();
        drainAll(1'b0);
        checkOutput("t4_ch0_mag", gotMag[0], 40);
        checkOutput("t4_ch0_phase", gotPhase[0], 100);

        $display("[TB] ties and PRN change, complete pending during compare");
        startSearch(100);
        checkOutput("t5_overrun_clr", int'(bus.overrun), 0);
        for (int k = 0; k < NCH; k++) begin cellSat[k] = k + 1; cellI[k] = k; cellQ[k] = k; end
        cellSat[4] = 4; cellSat[5] = 4;
        cellI[4] = 150; cellQ[4] = 0; cellI[5] = 60; cellQ[5] = 0;
        applyStimulus(2, 1, 11, 1'b1, 1'b0);
        repeat (NCH) tick();
        cellI[4] = -75; cellQ[4] = 75; cellI[5] = 90; cellQ[5] = 0;
        applyStimulus(7, 2, 22, 1'b1, 1'b0);
        repeat (NCH) tick();
        cellI[4] = 10; cellQ[4] = 0; cellSat[5] = 11; cellI[5] = 5; cellQ[5] = 5;
        applyStimulus(9, 3, 33, 1'b1, 1'b0);
        repeat (3) tick();
        searchComplete();
        drainAll(1'b0);
        checkOutput("t5_tie_phase", gotPhase[4], 2);
        checkOutput("t5_tie_mag", gotMag[4], 150);
        checkOutput("t5_new_sat", gotSat[5], 11);
        checkOutput("t5_new_mag", gotMag[5], 10);

        $display("[TB] backpressure on the result stream");
        startSearch(0);
        for (int k = 0; k < NCH; k++) begin cellSat[k] = k + 1; cellI[k] = 3*k + 1; cellQ[k] = 3*k + 1; end
        applyStimulus(1, 1, -5, 1'b1, 1'b0);
        repeat (NCH) tick();
        searchComplete();
        drainAll(1'b1);
        checkOutput("t6_records", recCount, NCH);

        $display("[TB] reset in the middle of a drain");
        startSearch(0);
        applyStimulus(4, 4, 4, 1'b1, 1'b0);
        repeat (NCH) tick();
        searchComplete();
        bus.res_ready = 1'b1;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        checkOutput("t1_valid", int'(bus.res_valid), 0);
        checkOutput("t1_busy", int'(bus.busy), 0);
        checkOutput("t1_mag", int'(bus.res_mag), 0);
        checkOutput("t1_sat", int'(bus.res_sat), 0);
        tick();
        rst_n = 1'b1;
        bus.res_ready = 1'b0;
        tick();
        applyStimulus(6, 6, 6, 1'b0, 1'b0);
        checkOutput("t1_idle_ignores", int'(bus.busy), 0);
        tick();
        checkOutput("t1_idle_valid", int'(bus.res_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
